multiplexador_displays: RTL

Time-multiplexed scan controller for a bank of common-anode 7-segment displays that share one segment bus. It drives the team's existing hex-to-7-segment decoder, which it instantiates internally, with one nibble at a time. It also selects the matching digit enable and inserts a blanking guard between digits to suppress ghosting. A load strobe updates the displayed value without tearing: new data is applied only at a frame boundary.

---
 rtl/multiplexador_displays.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multiplexador_displays.sv
// Time-multiplexed scan controller for common-anode 7-segment displays.
// One digit is driven per slot. Each slot opens with a blanking guard.
// Loaded values are held in a pending register and reach the display only
// at a frame boundary, so a displayed value never tears mid-frame.

// Hex nibble to 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);
    // Combinational lookup of the segment pattern for one nibble.
    always_comb begin
        seg_n = 7'h7F;
        case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
    end
endmodule

module multiplexador_displays #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     digit_en,
    output logic                    updated
);
    localparam int CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW      = 4 * N_DIGITS;
    localparam int BLANK_I = BLANK_CYCLES;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // With no guard cycles the slot starts directly in SHOW.
    localparam state_t STATE_RST = (BLANK_CYCLES > 0) ? GUARD : SHOW;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic                  shadow_lz_q, shadow_lz_d;
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                  updated_q, updated_d;

    logic                  frame_end;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  suppressed;

    // lead_zero[i] is set when every nibble from the top down to i is zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_lead_zero
            assign lead_zero[gi] = (shadow_val_q[VW-1:4*gi] == '0);
        end
    endgenerate

    assign frame_end  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign nibble     = 4'(shadow_val_q >> {idx_q, 2'b00});
    assign suppressed = shadow_lz_q && (idx_q != '0) && 1'(lead_zero >> idx_q);

    hex_to_7seg u_dec (
        .hex   (nibble),
        .seg_n (dec_seg)
    );

    // Slot counter, digit index and the per-slot GUARD/SHOW phase.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d = (int'(cnt_d) < BLANK_I) ? GUARD : SHOW;
    end

    // Pending/shadow handoff: boundary moves the old pending value, a load
    // in the same cycle re-arms pending for the following frame.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_lz_d  = shadow_lz_q;
        pend_val_d   = pend_val_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        if (frame_end && pend_valid_q) begin
            shadow_val_d = pend_val_q;
            shadow_lz_d  = pend_lz_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_val_d   = value_in;
            pend_lz_d    = lz_en;
            pend_valid_d = 1'b1;
        end
    end

    // Registered outputs derived from the current phase and digit index.
    always_comb begin
        seg_d      = 7'h7F;
        digit_en_d = '1;
        updated_d  = frame_end && pend_valid_q;
        if ((state_q == SHOW) && !suppressed) begin
            seg_d      = dec_seg;
            digit_en_d = ~(N_DIGITS'(1) << idx_q);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_RST;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_lz_q  <= 1'b0;
            pend_val_q   <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h7F;
            digit_en_q   <= '1;
            updated_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_lz_q  <= shadow_lz_d;
            pend_val_q   <= pend_val_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            updated_q    <= updated_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;
    assign updated  = updated_q;

endmodule
